// File: rtl/io_port_pkg.sv
// Shared constants for the CPU-facing I/O port bridge: address map and port geometry.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package io_port_pkg;

  localparam int NPORTS = 4;
  localparam int PORT_W = 32;

  // Word offsets within the I/O window (addr[7:0], addr[7] selects the window)
  localparam logic [7:0] OUT0   = 8'h80;
  localparam logic [7:0] OUT1   = 8'h84;
  localparam logic [7:0] OUT2   = 8'h88;
  localparam logic [7:0] OUT3   = 8'h8C;
  localparam logic [7:0] IN0    = 8'hC0;
  localparam logic [7:0] IN1    = 8'hC4;
  localparam logic [7:0] IN2    = 8'hC8;
  localparam logic [7:0] IN3    = 8'hCC;
  localparam logic [7:0] STATUS = 8'hD0;

  // Offset of output port n; ports sit on consecutive words
  function automatic logic [7:0] out_off(input int n);
    return OUT0 + 8'(4 * n);
  endfunction

  // Offset of input port n; ports sit on consecutive words
  function automatic logic [7:0] in_off(input int n);
    return IN0 + 8'(4 * n);
  endfunction

endpackage

// File: rtl/port_debounce.sv
// Two-flop synchroniser plus whole-word debouncer for one raw input port.
// Latency: a held change reaches value DEBOUNCE_CYCLES+3 edges after it appears.
// Backpressure: none; free-running, accept is a one-cycle pulse.
module port_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WIDTH           = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] value,
  output logic             accept
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] s2_d;
  logic [WIDTH-1:0] stable;
  logic [CW-1:0]    cnt;
  logic             holding;

  // A candidate differs from the accepted word and did not move this cycle;
  // any single-bit toggle drops holding and restarts the count.
  assign holding = (s2 != stable) && (s2 == s2_d);
  // Combinational so the parent's change flag sets on the same edge as stable
  assign accept  = holding && (cnt == CNT_LAST);
  assign value   = stable;

  // Synchroniser chain, debounce counter and accepted-value register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1     <= '0;
      s2     <= '0;
      s2_d   <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      s2_d <= s2;
      if (!holding) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_port_bridge.sv
// Memory-mapped I/O responder: four output port registers, four debounced input ports, change flags.
// Latency: stores land at the sampling edge; loads are combinational from registered state.
// Backpressure: none; every access completes in the cycle it is presented.
module io_port_bridge
  import io_port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        io_sel,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  input  logic [31:0] in_port2,
  input  logic [31:0] in_port3,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [31:0] out_port3
);

  logic [7:0]        offset;
  logic [PORT_W-1:0] out_reg [NPORTS];
  logic [PORT_W-1:0] in_raw  [NPORTS];
  logic [PORT_W-1:0] in_val  [NPORTS];
  logic [NPORTS-1:0] accept;
  logic [NPORTS-1:0] chg;
  logic              unused_addr;

  // Only the low byte is decoded; upper address bits belong to the CPU's memory map
  assign io_sel      = addr[7];
  assign offset      = addr[7:0];
  assign unused_addr = ^addr[31:8];

  assign in_raw[0] = in_port0;
  assign in_raw[1] = in_port1;
  assign in_raw[2] = in_port2;
  assign in_raw[3] = in_port3;

  assign out_port0 = out_reg[0];
  assign out_port1 = out_reg[1];
  assign out_port2 = out_reg[2];
  assign out_port3 = out_reg[3];

  for (genvar g = 0; g < NPORTS; g++) begin : g_in
    port_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .WIDTH          (PORT_W)
    ) u_deb (
      .clock (clock),
      .resetn(resetn),
      .raw   (in_raw[g]),
      .value (in_val[g]),
      .accept(accept[g])
    );
  end

  // Output port registers: a qualified store to a port's offset replaces it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < NPORTS; n++) out_reg[n] <= '0;
    end else if (we && io_sel) begin
      for (int n = 0; n < NPORTS; n++) begin
        if (offset == out_off(n)) out_reg[n] <= wdata;
      end
    end
  end

  // Change flags: set on accept, cleared by a load of that input port; set wins
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      chg <= '0;
    end else begin
      for (int n = 0; n < NPORTS; n++) begin
        if (accept[n]) begin
          chg[n] <= 1'b1;
        end else if (re && io_sel && (offset == in_off(n))) begin
          chg[n] <= 1'b0;
        end
      end
    end
  end

  // Read mux: decoded register or zero for anything unmapped or outside the window
  always_comb begin
    rdata = '0;
    if (io_sel) begin
      for (int n = 0; n < NPORTS; n++) begin
        if (offset == out_off(n)) rdata = out_reg[n];
        if (offset == in_off(n))  rdata = in_val[n];
      end
      if (offset == STATUS) rdata = {{(PORT_W - NPORTS){1'b0}}, chg};
    end
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge with DEBOUNCE_CYCLES=4.
// Stimulus queues expected values; a negedge monitor pops and compares.
// Kinds: 0 = rdata, 1..4 = out_port0..3, 5 = io_sel.
module tb_io_port_bridge;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        io_sel;
  logic [31:0] in_port0 = '0;
  logic [31:0] in_port1 = '0;
  logic [31:0] in_port2 = '0;
  logic [31:0] in_port3 = '0;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic [31:0] out_port3;

  always #5 clock = ~clock;

  io_port_bridge #(.DEBOUNCE_CYCLES(4)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .rdata    (rdata),
    .io_sel   (io_sel),
    .in_port0 (in_port0),
    .in_port1 (in_port1),
    .in_port2 (in_port2),
    .in_port3 (in_port3),
    .out_port0(out_port0),
    .out_port1(out_port1),
    .out_port2(out_port2),
    .out_port3(out_port3)
  );

  int          checks = 0;
  int          errors = 0;
  logic        mon_vld = 1'b0;
  int          kind_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];

  int          mon_k;
  logic [31:0] mon_e;
  logic [31:0] mon_a;
  string       mon_n;

  // Monitor: whenever the bench presents an observation, pop and compare
  always @(negedge clock) begin
    if (mon_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: observation with empty scoreboard");
      end else begin
        mon_k = kind_q.pop_front();
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        case (mon_k)
          1:       mon_a = out_port0;
          2:       mon_a = out_port1;
          3:       mon_a = out_port2;
          4:       mon_a = out_port3;
          5:       mon_a = {31'b0, io_sel};
          default: mon_a = rdata;
        endcase
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", mon_n, mon_a, mon_e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic observe(input int k, input logic [31:0] e, input string nm);
    kind_q.push_back(k);
    exp_q.push_back(e);
    name_q.push_back(nm);
    mon_vld = 1'b1;
    tick();
    mon_vld = 1'b0;
  endtask

  // Load: rdata sampled mid-cycle, re is seen by the DUT at the following edge
  task automatic load(input logic [31:0] a, input logic [31:0] e, input string nm);
    addr = a;
    re   = 1'b1;
    observe(0, e, nm);
    re   = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic check_port(input int n, input logic [31:0] e, input string nm);
    observe(n + 1, e, nm);
  endtask

  task automatic check_sel(input logic [31:0] a, input logic [31:0] e, input string nm);
    addr = a;
    observe(5, e, nm);
  endtask

  initial begin
    // Reset state
    tick();
    check_port(0, 32'h0, "rst_out0");
    check_port(1, 32'h0, "rst_out1");
    check_port(2, 32'h0, "rst_out2");
    check_port(3, 32'h0, "rst_out3");
    load(32'hD0, 32'h0, "rst_status");
    load(32'hC0, 32'h0, "rst_in0");
    resetn = 1'b1;
    tick(2);

    // Stores
    store(32'h84, 32'h0000_002A);
    check_port(1, 32'h2A, "store_out1");
    store(32'h8C, 32'h0000_0013);
    check_port(3, 32'h13, "store_out3");
    load(32'h84, 32'h2A, "load_out1");
    check_port(0, 32'h0, "untouched_out0");
    check_port(2, 32'h0, "untouched_out2");
    store(32'h80, 32'h1122_3344);
    load(32'h80, 32'h1122_3344, "load_out0");

    // Debounce accept on port 2: change before edge 1, accepted at edge 7
    in_port2 = 32'h15;
    tick(5);
    load(32'hC8, 32'h0, "deb2_before_e6");
    load(32'hC8, 32'h0, "deb2_before_e7");  // its re lands on the accept edge
    load(32'hD0, 32'h4, "deb2_status_set");
    load(32'hC8, 32'h15, "deb2_accepted");
    load(32'hD0, 32'h0, "deb2_chg_cleared");

    // Accept on port 1 colliding with a 0xC4 load on the same edge
    in_port1 = 32'h7;
    tick(6);
    load(32'hC4, 32'h0, "coll1_pre");
    load(32'hD0, 32'h2, "coll1_set_wins");
    load(32'hC4, 32'h7, "coll1_value");
    load(32'hD0, 32'h0, "coll1_cleared");

    // Glitch of 3 cycles on port 0 is rejected
    in_port0 = 32'h1F;
    tick(3);
    in_port0 = 32'h0;
    tick(8);
    load(32'hC0, 32'h0, "glitch_in0");
    load(32'hD0, 32'h0, "glitch_status");

    // Unmapped and ignored accesses
    store(32'hC0, 32'hFFFF_FFFF);
    store(32'hD0, 32'h0000_000F);
    load(32'hC0, 32'h0, "ro_in0");
    load(32'hD0, 32'h0, "ro_status");
    load(32'h90, 32'h0, "unmapped_90");
    store(32'h04, 32'hDEAD_BEEF);
    check_port(0, 32'h1122_3344, "nosel_out0");
    check_port(1, 32'h2A, "nosel_out1");
    check_port(3, 32'h13, "nosel_out3");
    check_sel(32'h04, 32'h0, "io_sel_low");
    check_sel(32'h84, 32'h1, "io_sel_high");
    load(32'h04, 32'h0, "nosel_rdata");

    // Reset mid-count on port 3, then re-debounce after release
    in_port3 = 32'h3C;
    tick(3);
    resetn = 1'b0;
    check_port(0, 32'h0, "midrst_out0");
    check_port(1, 32'h0, "midrst_out1");
    check_port(3, 32'h0, "midrst_out3");
    load(32'hD0, 32'h0, "midrst_status");
    load(32'hC8, 32'h0, "midrst_in2");
    load(32'hCC, 32'h0, "midrst_in3");
    resetn = 1'b1;
    tick(5);
    load(32'hCC, 32'h0, "redeb3_before_e6");
    load(32'hCC, 32'h0, "redeb3_before_e7");
    load(32'hCC, 32'h3C, "redeb3_accepted");
    load(32'hD0, 32'h6, "redeb_status");
    load(32'hC4, 32'h7, "redeb_in1");

    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_port_bridge.md
# io_port_bridge

Memory-mapped I/O responder that sits between the single-cycle CPU's data bus and the board-facing port wires. It holds the four CPU-written output port registers that feed the seven-segment display path. It also synchronises and debounces the four switch-derived input ports, and returns them to the CPU on loads. Per-port change flags let software poll for input edits.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before an input change is accepted; legal range ≥ 1
- clock  in  1  system clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- addr  in  32  CPU data address; only addr[7:0] decoded
- wdata  in  32  CPU store data
- we  in  1  store strobe, qualified by io_sel
- re  in  1  load strobe, qualified by io_sel; used only for read side-effects
- rdata  out  32  load data, combinational from registered state
- io_sel  out  1  combinational, = addr[7]; CPU uses it to steer between data memory and this block
- in_port0..in_port3  in  32 each  raw, asynchronous port inputs
- out_port0..out_port3  out  32 each  registered output ports

## Operation
- Address map, with io_sel=1 and word offsets:
  - 0x80/0x84/0x88/0x8C = out_port0..3, read/write
  - 0xC0/0xC4/0xC8/0xCC = in_port0..3 debounced values, read-only
  - 0xD0 = status {28'b0, chg[3:0]}, read-only
  - all other offsets read 0
- Stores:
  - we & io_sel to an out-port offset loads wdata into that register at the edge.
  - Stores to in-port, status or unmapped offsets are ignored.
- Loads:
  - rdata reflects the current registers for the decoded offset.
  - rdata = 0 when io_sel=0.
- Input path, per port and per bit:
  - Two-flop synchroniser s1 → s2, plus a delayed copy s2_d.
  - Debounce counter cnt:
    - cleared when s2 == stable or s2 != s2_d;
    - otherwise increments;
    - when it increments while equal to DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0, chg[n] set.
- chg[n] clear rule:
  - cleared at the edge where re & io_sel & addr = in_portn offset.
  - A same-cycle set wins over clear.
  - Reading status does not clear.
- Counter width is $clog2(DEBOUNCE_CYCLES+1).
- The whole 32-bit vector is debounced as one word; any bit toggle restarts the count.

## Timing
- Reset values:
  - out_port0..3 = 0.
  - s1, s2, s2_d, stable = 0; cnt = 0; chg = 0.
  - rdata follows decode, so a load of 0xC0 reads 0.
- Store latency: out_port updates at the edge where we is sampled and is visible immediately after it.
- Input latency: a raw change held steady appears in stable after the (DEBOUNCE_CYCLES+3)-th rising edge following the change. chg sets on the same edge.
- Glitch rejection: a change shorter than DEBOUNCE_CYCLES+1 cycles at s2 never reaches stable and does not set chg.
- Reversion: if s2 returns to stable mid-count, cnt clears and nothing is accepted.
- Simultaneous we and re: both are honoured independently.
- Reset mid-count: cnt and stable return to 0 asynchronously. After release, an input that is non-zero re-debounces from scratch.

## Structure
- Package io_port_pkg holds:
  - address offset constants (OUT0..OUT3, IN0..IN3, STATUS);
  - port count constant NPORTS = 4;
  - port data width constant 32.
- Sub-module port_debounce:
  - contains the synchroniser, counter, stable register and a one-cycle accept pulse;
  - parameterised by DEBOUNCE_CYCLES and width;
  - instantiated four times.
- Top level holds the decode, the out-port registers, the chg flags and the read mux.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4.
- Reset: assert resetn=0 mid-operation → all out_ports read 0, chg = 0, load of 0xD0 returns 0.
- Store: write 0x0000002A to 0x84, then 0x13 to 0x8C → out_port1 = 0x2A and out_port3 = 0x13, each on the store edge. Load of 0x84 returns 0x2A; out_port0/2 are unchanged.
- Debounce accept: set in_port2 = 0x15 and hold → load of 0xC8 reads 0 through edge 6 and 0x15 after edge 7. Status reads 0x4.
- Glitch reject: pulse in_port0 = 0x1F for 3 cycles, then back to 0 → 0xC0 stays 0 and chg[0] stays 0.
- Flag clear and collision:
  - load of 0xC8 clears chg[2];
  - a change on in_port1 accepted on the same edge as a 0xC4 load leaves chg[1] = 1.
- Unmapped and ignored:
  - store to 0xC0 or 0xD0 → no state change;
  - load of 0x90 → 0;
  - io_sel = 0 with we = 1 → out_ports unchanged.
